ctrl_conditioner: RTL

CTRL_CONDITIONER -- requirements
Module: ctrl_conditioner

---
 rtl/ctrl_conditioner_if.sv | 21 ++
 rtl/ctrl_conditioner.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ctrl_conditioner_if.sv
// Button, raster-position and conditioned-control signals exchanged with ctrl_conditioner.
// The master drives raw buttons and the raster position; the slave returns the conditioned controls.
interface ctrl_conditioner_if;
  logic [3:0]  btn_raw;
  logic        btn_start;
  logic [10:0] drawX;
  logic [10:0] drawY;
  logic [3:0]  controls;
  logic        frame_tick;
  logic        en;

  modport master (
    output btn_raw, btn_start, drawX, drawY,
    input  controls, frame_tick, en
  );

  modport slave (
    input  btn_raw, btn_start, drawX, drawY,
    output controls, frame_tick, en
  );
endinterface

// File: rtl/ctrl_conditioner.sv
// Synchronizes and debounces direction and start buttons, resolves opposing directions,
// and latches the directions once per frame alongside a one-cycle frame tick.
module ctrl_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FRAME_X         = 0,
  parameter int unsigned FRAME_Y         = 480,
  parameter bit          EN_RESET        = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst,
  ctrl_conditioner_if.slave  bus
);

  localparam int unsigned NUM_IN = 5;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned POS_W  = 11;

  localparam int unsigned UP    = 0;
  localparam int unsigned LEFT  = 1;
  localparam int unsigned RIGHT = 2;
  localparam int unsigned DOWN  = 3;
  localparam int unsigned START = 4;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [POS_W-1:0] MATCH_X   = POS_W'(FRAME_X);
  localparam logic [POS_W-1:0] MATCH_Y   = POS_W'(FRAME_Y);

  logic [NUM_IN-1:0] raw_c;
  logic [NUM_IN-1:0] sync_meta_q;
  logic [NUM_IN-1:0] sync_q;
  logic [NUM_IN-1:0] stable_q;
  logic [CNT_W-1:0]  cnt_q [NUM_IN];

  logic [NUM_IN-1:0] mismatch_c;
  logic [NUM_IN-1:0] accept_c;
  logic [3:0]        resolved_c;
  logic              frame_match_c;
  logic              start_press_c;

  logic [3:0]        controls_q;
  logic              frame_tick_q;
  logic              en_q;

  assign raw_c = {bus.btn_start, bus.btn_raw};

  // Two-flop synchronizer on every raw button.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= raw_c;
      sync_q      <= sync_meta_q;
    end
  end

  // A change is accepted on the last of DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    mismatch_c = '0;
    accept_c   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mismatch_c[i] = sync_q[i] ^ stable_q[i];
      accept_c[i]   = mismatch_c[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Per-input run counters; cleared on agreement or acceptance, so they never wrap.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!mismatch_c[i] || accept_c[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_q ^ accept_c;
    end
  end

  // Opposing directions held together cancel each other; diagonals pass through.
  always_comb begin
    resolved_c = stable_q[3:0];
    if (stable_q[UP] && stable_q[DOWN]) begin
      resolved_c[UP]   = 1'b0;
      resolved_c[DOWN] = 1'b0;
    end
    if (stable_q[LEFT] && stable_q[RIGHT]) begin
      resolved_c[LEFT]  = 1'b0;
      resolved_c[RIGHT] = 1'b0;
    end
  end

  assign frame_match_c = (bus.drawX == MATCH_X) && (bus.drawY == MATCH_Y);
  assign start_press_c = accept_c[START] && sync_q[START];

  // Controls sample the pre-edge stable bits on the same edge the tick rises.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      frame_tick_q <= 1'b0;
      controls_q   <= '0;
    end else begin
      frame_tick_q <= frame_match_c;
      if (frame_match_c) begin
        controls_q <= resolved_c;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      en_q <= EN_RESET;
    end else if (start_press_c) begin
      en_q <= ~en_q;
    end
  end

  assign bus.controls   = controls_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.en         = en_q;

endmodule
